// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter slice.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FRAME = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of a requester index; never below 1 bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping to 0.
module rr_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Upper segment (index >= ptr) has priority over the wrapped lower segment.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (IDW'(i) >= ptr)) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX among NUM_REQ byte sources.
// Optional: define UART_TX_ARB_BURST_EN to let an owner keep the TX for up to
// BURST_LEN consecutive frames while it stays valid.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      ARSTn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        cfg_par_en,
  input  logic [NUM_REQ-1:0]        cfg_par_typ,
  output logic                      tx_data_valid,
  output logic [DATA_W-1:0]         tx_p_data,
  output logic                      tx_par_en,
  output logic                      tx_par_typ,
  input  logic                      tx_busy,
  output logic [id_w(NUM_REQ)-1:0]  grant_id,
  output logic                      frame_done
);

  localparam int IDW = id_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1) begin : g_cfg_err
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and BURST_LEN >= 1");
  end

  function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] v);
    return (v == IDW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  state_t               state, state_n;
  logic [IDW-1:0]       ptr, ptr_n, arb_ptr;
  logic [NUM_REQ-1:0]   gnt, ready_n;
  logic [IDW-1:0]       gnt_idx, gid_n;
  logic                 gnt_any;
  logic                 dv_n, done_n, pe_n, pt_n, sel_pe, sel_pt;
  logic [DATA_W-1:0]    data_n, sel_data;

`ifdef UART_TX_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0] burst_cnt, burst_cnt_n;
  // Burst exhausted: scan starts past the owner, otherwise the held pointer re-picks it.
  assign arb_ptr = (burst_cnt >= CNT_W'(BURST_LEN)) ? inc_id(grant_id) : ptr;
`else
  assign arb_ptr = ptr;
`endif

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
    .req (req_valid),
    .ptr (arb_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // One-hot mux of the winner's byte and parity config.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
    sel_pe = |(cfg_par_en & gnt);
    sel_pt = |(cfg_par_typ & gnt);
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    ready_n = '0;
    dv_n    = 1'b0;
    done_n  = 1'b0;
    data_n  = tx_p_data;
    pe_n    = tx_par_en;
    pt_n    = tx_par_typ;
    gid_n   = grant_id;
`ifdef UART_TX_ARB_BURST_EN
    burst_cnt_n = burst_cnt;
`endif
    unique case (state)
      IDLE: begin
`ifdef UART_TX_ARB_BURST_EN
        // Owner went away: burst ends and the pointer moves past it.
        if (burst_cnt != '0 && !req_valid[grant_id]) begin
          burst_cnt_n = '0;
          ptr_n       = inc_id(grant_id);
        end
`endif
        // frame_done cycle never grants, so a lone requester gets an IDLE gap.
        if (gnt_any && !tx_busy && !frame_done) begin
          state_n = ISSUE;
          ready_n = gnt;
          data_n  = sel_data;
          pe_n    = sel_pe;
          pt_n    = sel_pt;
          gid_n   = gnt_idx;
`ifdef UART_TX_ARB_BURST_EN
          ptr_n       = gnt_idx;
          burst_cnt_n = (gnt_idx == grant_id && burst_cnt != '0 &&
                         burst_cnt < CNT_W'(BURST_LEN)) ? burst_cnt + 1'b1 : CNT_W'(1);
`else
          ptr_n = inc_id(gnt_idx);
`endif
        end
      end
      ISSUE: begin
        if (tx_busy) state_n = FRAME;
        else         dv_n    = 1'b1;
      end
      FRAME: begin
        if (!tx_busy) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      state         <= IDLE;
      ptr           <= '0;
      req_ready     <= '0;
      tx_data_valid <= 1'b0;
      tx_p_data     <= '0;
      tx_par_en     <= 1'b0;
      tx_par_typ    <= PAR_EVEN;
      grant_id      <= '0;
      frame_done    <= 1'b0;
`ifdef UART_TX_ARB_BURST_EN
      burst_cnt     <= '0;
`endif
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      req_ready     <= ready_n;
      tx_data_valid <= dv_n;
      tx_p_data     <= data_n;
      tx_par_en     <= pe_n;
      tx_par_typ    <= pt_n;
      grant_id      <= gid_n;
      frame_done    <= done_n;
`ifdef UART_TX_ARB_BURST_EN
      burst_cnt     <= burst_cnt_n;
`endif
    end
  end

endmodule
